// File: rtl/minilogix_pkg.sv
// Shared state encoding, default sizing and small helpers for the minilogix
// configuration loader.
package minilogix_pkg;

  localparam int DEF_CFG_BITS = 128;
  localparam int DEF_CLK_DIV  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_TRAIL,
    ST_DONE
  } cfg_state_e;

  // States that run off the load_clk divider.
  function automatic logic is_timed(input cfg_state_e s);
    return (s == ST_SHIFT_LO) || (s == ST_SHIFT_HI) || (s == ST_TRAIL);
  endfunction

  function automatic logic is_busy(input cfg_state_e s);
    return (s == ST_WAIT_BYTE) || is_timed(s);
  endfunction

endpackage

// File: rtl/minilogix_clkdiv.sv
// Half-period divider for load_clk: counts enabled cycles and pulses tc on the
// last one, restarting itself so each timed state lasts exactly CLK_DIV cycles.
module minilogix_clkdiv
  import minilogix_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign tc = en && !load && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load || tc) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/minilogix_cfg_tx.sv
// Serialises configuration bytes (MSB first) onto the minilogix1 load
// interface with a divided load_clk; all outputs are registered.
module minilogix_cfg_tx
  import minilogix_pkg::*;
#(
  parameter int CFG_BITS = DEF_CFG_BITS,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_load_en,
  output logic       o_load_clk,
  output logic       o_load_dat
);

  localparam int BW = $clog2(CFG_BITS + 1);
  localparam logic [BW-1:0] BITS_INIT = BW'(CFG_BITS);
  localparam logic [BW-1:0] BITS_ONE  = BW'(1);

  // Reset asserts asynchronously but is released two clocks after rst_n rises.
  logic rst_meta_reg;
  logic rst_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= rst_meta_reg;
    end
  end

  cfg_state_e    state_reg, state_next;
  logic [7:0]    shift_reg, shift_next;
  logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]    byte_bit_reg, byte_bit_next;
  logic          div_en;
  logic          div_load;
  logic          div_tc;

  assign div_en   = is_timed(state_reg);
  assign div_load = !div_en;

  minilogix_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk   (clk),
    .rst_n (rst_sync_reg),
    .load  (div_load),
    .en    (div_en),
    .tc    (div_tc)
  );

  always_ff @(posedge clk or negedge rst_sync_reg) begin
    if (!rst_sync_reg) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      byte_bit_reg <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_bit_reg <= byte_bit_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_bit_next = byte_bit_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next   = ST_WAIT_BYTE;
          bit_cnt_next = BITS_INIT;
        end
      end
      ST_WAIT_BYTE: begin
        if (i_byte_valid && o_byte_ready) begin
          shift_next    = i_byte;
          byte_bit_next = '0;
          state_next    = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (div_tc) state_next = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (div_tc) begin
          shift_next    = {shift_reg[6:0], 1'b0};
          bit_cnt_next  = bit_cnt_reg - 1'b1;
          byte_bit_next = byte_bit_reg + 1'b1;
          // A short final byte ends the frame here; its unused low bits are dropped.
          if (bit_cnt_reg == BITS_ONE)   state_next = ST_TRAIL;
          else if (byte_bit_reg == 3'd7) state_next = ST_WAIT_BYTE;
          else                           state_next = ST_SHIFT_LO;
        end
      end
      ST_TRAIL: begin
        if (div_tc) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge rst_sync_reg) begin
    if (!rst_sync_reg) begin
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_load_en    <= 1'b0;
      o_load_clk   <= 1'b0;
      o_load_dat   <= 1'b0;
    end else begin
      o_byte_ready <= (state_next == ST_WAIT_BYTE);
      o_busy       <= is_busy(state_next);
      o_done       <= (state_next == ST_DONE);
      o_load_en    <= is_busy(state_next);
      o_load_clk   <= (state_next == ST_SHIFT_HI);
      if (state_next == ST_SHIFT_LO) begin
        o_load_dat <= shift_next[7];
      end else if ((state_next == ST_IDLE) || (state_next == ST_DONE)) begin
        o_load_dat <= 1'b0;
      end
    end
  end

endmodule
